// File: rtl/ps2_dual_packet_arbiter.sv
// Frames two PS/2-style byte streams into 3-byte packets, buffers one packet per
// stream and round-robin arbitrates them onto a registered valid/ready output.
module ps2_dual_packet_arbiter #(
    parameter int unsigned SYNC_BIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in0_valid,
    input  logic [7:0]  in0_byte,
    input  logic        in1_valid,
    input  logic [7:0]  in1_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_bytes,
    output logic        out_src,
    output logic        drop0,
    output logic        drop1
);

    localparam logic [2:0] SYNC_IDX = 3'(SYNC_BIT);

    typedef enum logic [1:0] {SEARCH, B2, B3} frame_state_t;

    logic [1:0]  in_valid;
    logic [7:0]  in_byte [2];
    logic [1:0]  hold_valid;
    logic [23:0] hold_data [2];
    logic [1:0]  take;
    logic [1:0]  drop;
    logic        out_load;
    logic        last_src;

    assign in_valid   = {in1_valid, in0_valid};
    assign in_byte[0] = in0_byte;
    assign in_byte[1] = in1_byte;
    assign drop0      = drop[0];
    assign drop1      = drop[1];

    // On a tie the stream not granted last wins; take is one-hot or zero.
    always_comb begin
        out_load = !out_valid || out_ready;
        take     = '0;
        if (out_load) begin
            if (&hold_valid) take = last_src ? 2'b01 : 2'b10;
            else             take = hold_valid;
        end
    end

    genvar s;
    generate
        for (s = 0; s < 2; s++) begin : g_stream
            frame_state_t state_q, state_d;
            logic [7:0]   byte1_q, byte2_q;
            logic         hold_valid_q, drop_q, complete;
            logic [23:0]  hold_data_q;

            always_comb begin
                state_d  = state_q;
                complete = 1'b0;
                if (in_valid[s]) begin
                    case (state_q)
                        SEARCH:  if (in_byte[s][SYNC_IDX]) state_d = B2;
                        B2:      state_d = B3;
                        B3: begin
                            state_d  = SEARCH;
                            complete = 1'b1;
                        end
                        default: state_d = SEARCH;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q      <= SEARCH;
                    byte1_q      <= '0;
                    byte2_q      <= '0;
                    hold_valid_q <= 1'b0;
                    hold_data_q  <= '0;
                    drop_q       <= 1'b0;
                end else begin
                    state_q <= state_d;
                    drop_q  <= 1'b0;
                    if (in_valid[s] && state_q == SEARCH) byte1_q <= in_byte[s];
                    if (in_valid[s] && state_q == B2)     byte2_q <= in_byte[s];
                    // A buffer being granted this cycle counts as free for a completion.
                    if (complete) begin
                        if (!hold_valid_q || take[s]) begin
                            hold_valid_q <= 1'b1;
                            hold_data_q  <= {byte1_q, byte2_q, in_byte[s]};
                        end else begin
                            drop_q <= 1'b1;
                        end
                    end else if (take[s]) begin
                        hold_valid_q <= 1'b0;
                    end
                end
            end

            assign hold_valid[s] = hold_valid_q;
            assign hold_data[s]  = hold_data_q;
            assign drop[s]       = drop_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bytes <= '0;
            out_src   <= 1'b0;
            last_src  <= 1'b1;
        end else if (out_load) begin
            if (|take) begin
                out_valid <= 1'b1;
                out_bytes <= hold_data[take[1]];
                out_src   <= take[1];
                last_src  <= take[1];
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_dual_packet_arbiter.sv
// Table-driven directed vectors plus randomized stimulus checked against a
// byte-count / queue-level reference model of the dual packet arbiter.
module tb_ps2_dual_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset, in0_valid, in1_valid, out_ready;
    logic [7:0]  in0_byte, in1_byte;
    logic        out_valid, out_src, drop0, drop1;
    logic [23:0] out_bytes;
    logic        s0_valid, s0_src, s0_drop0, s0_drop1;
    logic [23:0] s0_bytes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ps2_dual_packet_arbiter dut (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_byte(in0_byte),
        .in1_valid(in1_valid), .in1_byte(in1_byte),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bytes(out_bytes), .out_src(out_src),
        .drop0(drop0), .drop1(drop1)
    );

    ps2_dual_packet_arbiter #(.SYNC_BIT(0)) dut_s0 (
        .clk(clk), .reset(reset),
        .in0_valid(in0_valid), .in0_byte(in0_byte),
        .in1_valid(in1_valid), .in1_byte(in1_byte),
        .out_valid(s0_valid), .out_ready(out_ready),
        .out_bytes(s0_bytes), .out_src(s0_src),
        .drop0(s0_drop0), .drop1(s0_drop1)
    );

    // Reference model for the SYNC_BIT=3 instance: bytes collected per stream,
    // one-deep holding slot per stream, one output slot, last-granted stream.
    int          m_cnt [2];
    logic [23:0] m_part [2];
    logic [23:0] m_hd [2];
    bit          m_hv [2];
    bit          m_drop [2];
    bit          m_ov, m_os, m_last;
    logic [23:0] m_ob;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_byte(input bit s, input bit v, input logic [7:0] b);
        m_drop[s] = 1'b0;
        if (v) begin
            if (m_cnt[s] == 0) begin
                if (b[3]) begin
                    m_part[s] = {b, 16'h0000};
                    m_cnt[s]  = 1;
                end
            end else if (m_cnt[s] == 1) begin
                m_part[s] = m_part[s] | {8'h00, b, 8'h00};
                m_cnt[s]  = 2;
            end else begin
                m_cnt[s] = 0;
                if (!m_hv[s]) begin
                    m_hv[s] = 1'b1;
                    m_hd[s] = m_part[s] | {16'h0000, b};
                end else begin
                    m_drop[s] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_step(input bit rst, input bit v0, input logic [7:0] b0,
                              input bit v1, input logic [7:0] b1, input bit rdy);
        bit have, gs;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_part[i] = '0; m_hd[i] = '0; m_hv[i] = 0; m_drop[i] = 0;
            end
            m_ov = 0; m_os = 0; m_last = 1; m_ob = '0;
            return;
        end
        have = 0; gs = 0;
        if (!m_ov || rdy) begin
            if (m_hv[0] && m_hv[1]) begin have = 1; gs = !m_last; end
            else if (m_hv[0])       begin have = 1; gs = 0; end
            else if (m_hv[1])       begin have = 1; gs = 1; end
            if (have) begin
                m_ov = 1; m_ob = m_hd[gs]; m_os = gs; m_last = gs; m_hv[gs] = 0;
            end else begin
                m_ov = 0;
            end
        end
        model_byte(0, v0, b0);
        model_byte(1, v1, b1);
    endtask

    task automatic apply(input bit rst, input bit v0, input logic [7:0] b0,
                         input bit v1, input logic [7:0] b1, input bit rdy);
        reset = rst; in0_valid = v0; in0_byte = b0;
        in1_valid = v1; in1_byte = b1; out_ready = rdy;
        model_step(rst, v0, b0, v1, b1, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, " out_bytes"}, 32'(out_bytes), 32'(m_ob));
        check({tag, " out_src"},   32'(out_src),   32'(m_os));
        check({tag, " drop0"},     32'(drop0),     32'(m_drop[0]));
        check({tag, " drop1"},     32'(drop1),     32'(m_drop[1]));
    endtask

    typedef struct {
        bit          rst, v0, v1, rdy;
        logic [7:0]  b0, b1;
        bit          ov, os, d0, d1;
        logic [23:0] ob;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rst, bit v0, logic [7:0] b0, bit v1, logic [7:0] b1, bit rdy,
                                bit ov, logic [23:0] ob, bit os, bit d0, bit d1);
        vec_t r;
        r.rst = rst; r.v0 = v0; r.b0 = b0; r.v1 = v1; r.b1 = b1; r.rdy = rdy;
        r.ov = ov; r.ob = ob; r.os = os; r.d0 = d0; r.d1 = d1;
        tbl.push_back(r);
    endfunction

    initial begin
        reset = 1; in0_valid = 0; in0_byte = '0; in1_valid = 0; in1_byte = '0; out_ready = 1;

        // reset, then single stream-0 packet with 2-edge latency
        add(1,0,8'h00,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,1,8'h08,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,1,8'h12,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,1,8'h34,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h081234,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h081234,0,0,0);
        // stream 1 resync and gaps
        add(0,0,8'h00,1,8'h00,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,1,8'hF7,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,1,8'h18,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,1,8'hAA,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,1,8'h55,1, 0,24'h081234,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h18AA55,1,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h18AA55,1,0,0);
        // simultaneous completion, round 1
        add(0,1,8'h08,1,8'h09,1, 0,24'h18AA55,1,0,0);
        add(0,1,8'h01,1,8'h03,1, 0,24'h18AA55,1,0,0);
        add(0,1,8'h02,1,8'h04,1, 0,24'h18AA55,1,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h080102,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h090304,1,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h090304,1,0,0);
        // round 2: stream 0 wins again
        add(0,1,8'h0A,1,8'h0B,1, 0,24'h090304,1,0,0);
        add(0,1,8'h05,1,8'h07,1, 0,24'h090304,1,0,0);
        add(0,1,8'h06,1,8'h08,1, 0,24'h090304,1,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h0A0506,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h0B0708,1,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h0B0708,1,0,0);
        // backpressure: P1 to output, P2 to holding, P3 dropped
        add(0,1,8'h08,0,8'h00,0, 0,24'h0B0708,1,0,0);
        add(0,1,8'h00,0,8'h00,0, 0,24'h0B0708,1,0,0);
        add(0,1,8'h01,0,8'h00,0, 0,24'h0B0708,1,0,0);
        add(0,1,8'h08,0,8'h00,0, 1,24'h080001,0,0,0);
        add(0,1,8'h00,0,8'h00,0, 1,24'h080001,0,0,0);
        add(0,1,8'h02,0,8'h00,0, 1,24'h080001,0,0,0);
        add(0,1,8'h08,0,8'h00,0, 1,24'h080001,0,0,0);
        add(0,1,8'h00,0,8'h00,0, 1,24'h080001,0,0,0);
        add(0,1,8'h03,0,8'h00,0, 1,24'h080001,0,1,0);
        add(0,0,8'h00,0,8'h00,0, 1,24'h080001,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h080002,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h080002,0,0,0);
        // reset mid-operation
        add(0,0,8'h00,1,8'h09,0, 0,24'h080002,0,0,0);
        add(0,0,8'h00,1,8'h00,0, 0,24'h080002,0,0,0);
        add(0,0,8'h00,1,8'h01,0, 0,24'h080002,0,0,0);
        add(0,1,8'h08,1,8'h09,0, 1,24'h090001,1,0,0);
        add(0,1,8'h11,1,8'h00,0, 1,24'h090001,1,0,0);
        add(0,0,8'h00,1,8'h02,0, 1,24'h090001,1,0,0);
        add(1,0,8'h00,0,8'h00,0, 0,24'h000000,0,0,0);
        add(0,1,8'h22,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,1,8'h08,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,1,8'h33,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,1,8'h44,0,8'h00,1, 0,24'h000000,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 1,24'h083344,0,0,0);
        add(0,0,8'h00,0,8'h00,1, 0,24'h083344,0,0,0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].v0, tbl[i].b0, tbl[i].v1, tbl[i].b1, tbl[i].rdy);
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("row%0d out_bytes", i), 32'(out_bytes), 32'(tbl[i].ob));
            check($sformatf("row%0d out_src", i),   32'(out_src),   32'(tbl[i].os));
            check($sformatf("row%0d drop0", i),     32'(drop0),     32'(tbl[i].d0));
            check($sformatf("row%0d drop1", i),     32'(drop1),     32'(tbl[i].d1));
        end

        // SYNC_BIT=0 instance: 0x08 skipped, packet 0x010203
        apply(1,0,8'h00,0,8'h00,1);
        check("sync0 reset valid", 32'(s0_valid), 32'd0);
        apply(0,1,8'h08,0,8'h00,1);
        apply(0,1,8'h01,0,8'h00,1);
        apply(0,1,8'h02,0,8'h00,1);
        apply(0,1,8'h03,0,8'h00,1);
        check("sync0 latency valid", 32'(s0_valid), 32'd0);
        check_model("sync3 side");
        apply(0,0,8'h00,0,8'h00,1);
        check("sync0 valid", 32'(s0_valid), 32'd1);
        check("sync0 bytes", 32'(s0_bytes), 32'h010203);
        check("sync0 src",   32'(s0_src),   32'd0);

        // randomized run against the reference model
        apply(1,0,8'h00,0,8'h00,1);
        check_model("rand reset");
        for (int n = 0; n < 4000; n++) begin
            bit          rst, v0, v1, rdy;
            logic [7:0]  b0, b1;
            rst = ($urandom_range(0, 499) == 0);
            v0  = ($urandom_range(0, 2) != 0);
            v1  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            b0  = 8'($urandom_range(0, 255));
            b1  = 8'($urandom_range(0, 255));
            apply(rst, v0, b0, v1, b1, rdy);
            check_model($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
